bayer_mosaic: RTL and testbench



---
 rtl/bayer_mosaic.sv | 160 ++++++++++++++++
 tb/tb_bayer_mosaic.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bayer_mosaic.sv
// Bayer re-mosaic: RGB 8:8:8 video in, single-channel 8-bit raw Bayer out.
// Also measures frame geometry (pixels per line, lines per frame) against
// the configured size and raises sticky error flags on mismatch.
//
// Ports:
//   clk, reset                      pixel clock, synchronous active-high reset
//   in_vsync/in_hsync/in_den        input sync and pixel-valid
//   in_data_R/G/B                   input colour samples
//   cfg_pattern                     CFA phase (0 RGGB, 1 GRBG, 2 GBRG, 3 BGGR),
//                                   taken on the rising edge of in_vsync
//   out_vsync/out_hsync/out_den     input syncs delayed by 2 cycles
//   out_raw                         selected sample, 0 when out_den is low
//   err_hsize/err_vsize             sticky geometry mismatch flags
//   frame_cnt                       completed frames (wrapping)
module bayer_mosaic #(
  parameter int unsigned source_h        = 512,
  parameter int unsigned source_v        = 512,
  parameter logic [1:0]  default_pattern = 2'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_vsync,
  input  logic        in_hsync,
  input  logic        in_den,
  input  logic [7:0]  in_data_R,
  input  logic [7:0]  in_data_G,
  input  logic [7:0]  in_data_B,
  input  logic [1:0]  cfg_pattern,
  output logic        out_vsync,
  output logic        out_hsync,
  output logic        out_den,
  output logic [7:0]  out_raw,
  output logic        err_hsize,
  output logic        err_vsize,
  output logic [15:0] frame_cnt
);

  // Edge detection and geometry state
  logic        vs_prev_q, hs_prev_q;
  logic        line_den_q, line_den_d;
  logic [11:0] x_q, x_d, y_q, y_d;
  logic [1:0]  pat_q, pat_d;
  logic        err_h_q, err_h_d, err_v_q, err_v_d;
  logic [15:0] frame_q, frame_d;

  // Pipeline stage 1
  logic       s1_vs_q, s1_hs_q, s1_den_q;
  logic [7:0] s1_r_q, s1_g_q, s1_b_q;
  logic [1:0] s1_phase_q, s1_pat_q;

  // Pipeline stage 2
  logic       s2_vs_q, s2_hs_q, s2_den_q;
  logic [7:0] raw_q, raw_d, raw_sel;

  logic        vs_rise, vs_fall, hs_fall, line_end;
  logic [11:0] y_line;
  logic [1:0]  pat_cur, phase;

  always_comb begin
    vs_rise  = in_vsync & ~vs_prev_q;
    vs_fall  = ~in_vsync & vs_prev_q;
    hs_fall  = ~in_hsync & hs_prev_q;
    line_end = hs_fall & line_den_q;

    // New pattern applies already to the vsync-rise cycle itself.
    pat_cur = vs_rise ? cfg_pattern : pat_q;
    pat_d   = pat_cur;
    phase   = {y_q[0], x_q[0]};

    // x counts den cycles inside a line; it is the index of the current pixel.
    x_d = x_q;
    if (!in_hsync || !in_vsync) begin
      x_d = '0;
    end else if (in_den) begin
      x_d = x_q + 12'd1;
    end

    line_den_d = line_den_q;
    if (!in_hsync) begin
      line_den_d = 1'b0;
    end else if (in_vsync && in_den) begin
      line_den_d = 1'b1;
    end

    // Line ending this cycle is counted before a coincident frame check.
    y_line = y_q + {11'd0, line_end};
    y_d    = in_vsync ? y_line : '0;

    err_h_d = err_h_q | (line_end & (x_q != 12'(source_h)));
    err_v_d = err_v_q | (vs_fall & (y_line != 12'(source_v)));
    frame_d = frame_q + {15'd0, vs_fall};
  end

  // Channel select: each pattern has exactly one R and one B site in the 2x2 tile.
  always_comb begin
    unique case ({s1_pat_q, s1_phase_q})
      4'b00_00, 4'b01_01, 4'b10_10, 4'b11_11: raw_sel = s1_r_q;
      4'b00_11, 4'b01_10, 4'b10_01, 4'b11_00: raw_sel = s1_b_q;
      default:                                raw_sel = s1_g_q;
    endcase
    raw_d = s1_den_q ? raw_sel : 8'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vs_prev_q  <= 1'b0;
      hs_prev_q  <= 1'b0;
      line_den_q <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      pat_q      <= default_pattern;
      err_h_q    <= 1'b0;
      err_v_q    <= 1'b0;
      frame_q    <= '0;
      s1_vs_q    <= 1'b0;
      s1_hs_q    <= 1'b0;
      s1_den_q   <= 1'b0;
      s1_r_q     <= '0;
      s1_g_q     <= '0;
      s1_b_q     <= '0;
      s1_phase_q <= '0;
      s1_pat_q   <= default_pattern;
      s2_vs_q    <= 1'b0;
      s2_hs_q    <= 1'b0;
      s2_den_q   <= 1'b0;
      raw_q      <= '0;
    end else begin
      vs_prev_q  <= in_vsync;
      hs_prev_q  <= in_hsync;
      line_den_q <= line_den_d;
      x_q        <= x_d;
      y_q        <= y_d;
      pat_q      <= pat_d;
      err_h_q    <= err_h_d;
      err_v_q    <= err_v_d;
      frame_q    <= frame_d;
      s1_vs_q    <= in_vsync;
      s1_hs_q    <= in_hsync;
      s1_den_q   <= in_den;
      s1_r_q     <= in_data_R;
      s1_g_q     <= in_data_G;
      s1_b_q     <= in_data_B;
      s1_phase_q <= phase;
      s1_pat_q   <= pat_cur;
      s2_vs_q    <= s1_vs_q;
      s2_hs_q    <= s1_hs_q;
      s2_den_q   <= s1_den_q;
      raw_q      <= raw_d;
    end
  end

  assign out_vsync = s2_vs_q;
  assign out_hsync = s2_hs_q;
  assign out_den   = s2_den_q;
  assign out_raw   = raw_q;
  assign err_hsize = err_h_q;
  assign err_vsize = err_v_q;
  assign frame_cnt = frame_q;

endmodule

// File: tb/tb_bayer_mosaic.sv
// Self-checking bench for bayer_mosaic (source_h = 4, source_v = 2).
// Each driven cycle pushes the expected output word; a negedge monitor
// captures the DUT output words; test tasks pop and compare both queues.
module tb_bayer_mosaic;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_vsync, in_hsync, in_den;
  logic [7:0]  in_data_R, in_data_G, in_data_B;
  logic [1:0]  cfg_pattern;
  logic        out_vsync, out_hsync, out_den;
  logic [7:0]  out_raw;
  logic        err_hsize, err_vsize;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  bayer_mosaic #(
    .source_h       (4),
    .source_v       (2),
    .default_pattern(2'd0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_vsync   (in_vsync),
    .in_hsync   (in_hsync),
    .in_den     (in_den),
    .in_data_R  (in_data_R),
    .in_data_G  (in_data_G),
    .in_data_B  (in_data_B),
    .cfg_pattern(cfg_pattern),
    .out_vsync  (out_vsync),
    .out_hsync  (out_hsync),
    .out_den    (out_den),
    .out_raw    (out_raw),
    .err_hsize  (err_hsize),
    .err_vsize  (err_vsize),
    .frame_cnt  (frame_cnt)
  );

  typedef struct packed {
    logic       vs;
    logic       hs;
    logic       den;
    logic [7:0] raw;
  } out_t;

  out_t exp_q[$];
  out_t obs_q[$];
  logic mon_en = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Colour at each 2x2 site: [pattern][{row, col}], 0 = R, 1 = G, 2 = B
  logic [1:0] cfa [4][4];

  always @(negedge clk) begin
    if (mon_en) obs_q.push_back(out_t'({out_vsync, out_hsync, out_den, out_raw}));
  end

  task automatic drv(input logic vs, hs, den, input logic [7:0] r, g, b, e);
    out_t t;
    in_vsync  = vs;
    in_hsync  = hs;
    in_den    = den;
    in_data_R = r;
    in_data_G = g;
    in_data_B = b;
    t = {vs, hs, den, e};
    exp_q.push_back(t);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drv(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
  endtask

  task automatic start_mon();
    out_t z;
    idle(2);
    exp_q.delete();
    obs_q.delete();
    mon_en = 1'b1;
    z = '0;
    exp_q.push_back(z);
    exp_q.push_back(z);
  endtask

  // One frame: 4 pixels per line except short_line (3); gap_line has a
  // 3-cycle den gap before pixel 2; sim_fall drops hsync with vsync.
  task automatic drive_frame(input int n_lines, input int short_line, input int gap_line,
                             input bit sim_fall, input logic [1:0] pat, input int cfg_mid);
    int         npix;
    logic [7:0] r, g, b, e;
    logic [1:0] site;
    drv(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
    drv(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
    for (int y = 0; y < n_lines; y++) begin
      npix = (y == short_line) ? 3 : 4;
      for (int px = 0; px < npix; px++) begin
        if (y == gap_line && px == 2)
          repeat (3) drv(1'b1, 1'b1, 1'b0, 8'hEE, 8'hEE, 8'hEE, 8'd0);
        r = 8'(8'h10 + px);
        g = 8'(8'h20 + px);
        b = 8'(8'h30 + px);
        site = {y[0], px[0]};
        case (cfa[pat][site])
          2'd0:    e = r;
          2'd1:    e = g;
          default: e = b;
        endcase
        drv(1'b1, 1'b1, 1'b1, r, g, b, e);
      end
      if (!(sim_fall && y == n_lines - 1)) begin
        drv(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        drv(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
      end
      if (y == 0 && cfg_mid >= 0) cfg_pattern = cfg_mid[1:0];
    end
    idle(2);
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    cfg_pattern = 2'd2;
    in_vsync    = 1'b1;
    in_hsync    = 1'b1;
    in_den      = 1'b1;
    in_data_R   = 8'hA5;
    in_data_G   = 8'h5A;
    in_data_B   = 8'hFF;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    n_tests++;
    if ({out_vsync, out_hsync, out_den} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_syncs: got %b, want 000", {out_vsync, out_hsync, out_den});
    end
    n_tests++;
    if (out_raw !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_raw: got %02h, want 00", out_raw);
    end
    n_tests++;
    if ({err_hsize, err_vsize} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, want 00", {err_hsize, err_vsize});
    end
    n_tests++;
    if (frame_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_frame_cnt: got %0d, want 0", frame_cnt);
    end
    reset = 1'b0;
    idle(3);
  endtask

  task automatic test_rggb();
    out_t o, e;
    int   idx;
    cfg_pattern = 2'd0;
    start_mon();
    drive_frame(2, -1, -1, 1'b0, 2'd0, -1);
    mon_en = 1'b0;
    idx = 0;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL rggb_stream[%0d]: got %p, want %p", idx, o, e);
      end
      idx++;
    end
    n_tests++;
    if ({err_hsize, err_vsize} !== 2'b00 || frame_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL rggb_status: got err=%b cnt=%0d, want err=00 cnt=1",
               {err_hsize, err_vsize}, frame_cnt);
    end
  endtask

  task automatic test_bggr();
    out_t o, e;
    int   idx;
    cfg_pattern = 2'd3;
    start_mon();
    drive_frame(2, -1, -1, 1'b0, 2'd3, -1);
    mon_en = 1'b0;
    idx = 0;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL bggr_stream[%0d]: got %p, want %p", idx, o, e);
      end
      idx++;
    end
    n_tests++;
    if ({err_hsize, err_vsize} !== 2'b00 || frame_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL bggr_status: got err=%b cnt=%0d, want err=00 cnt=2",
               {err_hsize, err_vsize}, frame_cnt);
    end
  endtask

  task automatic test_pattern_midframe();
    out_t o, e;
    int   idx;
    cfg_pattern = 2'd0;
    start_mon();
    // cfg switches to GRBG after line 0; this frame stays RGGB, the next is GRBG
    drive_frame(2, -1, -1, 1'b0, 2'd0, 1);
    drive_frame(2, -1, -1, 1'b0, 2'd1, -1);
    mon_en = 1'b0;
    idx = 0;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL midframe_stream[%0d]: got %p, want %p", idx, o, e);
      end
      idx++;
    end
    n_tests++;
    if (frame_cnt !== 16'd4) begin
      n_fail++;
      $display("FAIL midframe_frame_cnt: got %0d, want 4", frame_cnt);
    end
  endtask

  task automatic test_den_gap();
    out_t o, e;
    int   idx;
    cfg_pattern = 2'd0;
    start_mon();
    // Also lets the last hsync fall together with vsync
    drive_frame(2, -1, 0, 1'b1, 2'd0, -1);
    mon_en = 1'b0;
    idx = 0;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL gap_stream[%0d]: got %p, want %p", idx, o, e);
      end
      idx++;
    end
    n_tests++;
    if ({err_hsize, err_vsize} !== 2'b00 || frame_cnt !== 16'd5) begin
      n_fail++;
      $display("FAIL gap_status: got err=%b cnt=%0d, want err=00 cnt=5",
               {err_hsize, err_vsize}, frame_cnt);
    end
  endtask

  task automatic test_size_errors();
    cfg_pattern = 2'd0;
    idle(2);
    drive_frame(2, 1, -1, 1'b0, 2'd0, -1);
    n_tests++;
    if ({err_hsize, err_vsize} !== 2'b10 || frame_cnt !== 16'd6) begin
      n_fail++;
      $display("FAIL short_line: got err=%b cnt=%0d, want err=10 cnt=6",
               {err_hsize, err_vsize}, frame_cnt);
    end
    drive_frame(3, -1, -1, 1'b0, 2'd0, -1);
    n_tests++;
    if ({err_hsize, err_vsize} !== 2'b11 || frame_cnt !== 16'd7) begin
      n_fail++;
      $display("FAIL extra_line: got err=%b cnt=%0d, want err=11 cnt=7",
               {err_hsize, err_vsize}, frame_cnt);
    end
    drive_frame(2, -1, -1, 1'b0, 2'd0, -1);
    n_tests++;
    if ({err_hsize, err_vsize} !== 2'b11 || frame_cnt !== 16'd8) begin
      n_fail++;
      $display("FAIL sticky_flags: got err=%b cnt=%0d, want err=11 cnt=8",
               {err_hsize, err_vsize}, frame_cnt);
    end
  endtask

  task automatic test_reset_midline();
    out_t o, e;
    int   idx;
    cfg_pattern = 2'd0;
    idle(2);
    drv(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
    drv(1'b1, 1'b1, 1'b1, 8'h10, 8'h20, 8'h30, 8'h10);
    drv(1'b1, 1'b1, 1'b1, 8'h11, 8'h21, 8'h31, 8'h21);
    reset = 1'b1;
    drv(1'b1, 1'b1, 1'b1, 8'h12, 8'h22, 8'h32, 8'h12);
    n_tests++;
    if ({out_vsync, out_hsync, out_den} !== 3'b000 || out_raw !== 8'd0) begin
      n_fail++;
      $display("FAIL midline_reset_out: got syncs=%b raw=%02h, want 000 00",
               {out_vsync, out_hsync, out_den}, out_raw);
    end
    n_tests++;
    if ({err_hsize, err_vsize} !== 2'b00 || frame_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL midline_reset_state: got err=%b cnt=%0d, want err=00 cnt=0",
               {err_hsize, err_vsize}, frame_cnt);
    end
    reset = 1'b0;
    start_mon();
    drive_frame(2, -1, -1, 1'b0, 2'd0, -1);
    mon_en = 1'b0;
    idx = 0;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL post_reset_stream[%0d]: got %p, want %p", idx, o, e);
      end
      idx++;
    end
    n_tests++;
    if ({err_hsize, err_vsize} !== 2'b00 || frame_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL post_reset_status: got err=%b cnt=%0d, want err=00 cnt=1",
               {err_hsize, err_vsize}, frame_cnt);
    end
  endtask

  initial begin
    cfa[0] = '{2'd0, 2'd1, 2'd1, 2'd2};  // RGGB
    cfa[1] = '{2'd1, 2'd0, 2'd2, 2'd1};  // GRBG
    cfa[2] = '{2'd1, 2'd2, 2'd0, 2'd1};  // GBRG
    cfa[3] = '{2'd2, 2'd1, 2'd1, 2'd0};  // BGGR
    reset       = 1'b1;
    in_vsync    = 1'b0;
    in_hsync    = 1'b0;
    in_den      = 1'b0;
    in_data_R   = '0;
    in_data_G   = '0;
    in_data_B   = '0;
    cfg_pattern = '0;

    test_reset();
    test_rggb();
    test_bggr();
    test_pattern_midframe();
    test_den_gap();
    test_size_errors();
    test_reset_midline();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
